// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-to-RAM bridge: command codes, FSM states and the
// serial frame width (two command bits plus the wider of address and data).
package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        EXEC,
        TX,
        WAIT_HI
    } state_e;

    function automatic int frame_w(input int aw, input int dw);
        return 2 + ((aw > dw) ? aw : dw);
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port word RAM: synchronous write, registered read, no reset.
// Addresses at or beyond DEPTH never write and read back as zero.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;

    assign w_in_range = ({1'b0, i_addr} < DEPTH_V);
    assign w_idx      = i_addr[IDX_W-1:0];
    assign o_rdata    = r_rdata;

    always_ff @(posedge clk) begin
        if (i_we && w_in_range) begin
            r_mem[w_idx] <= i_wdata;
        end
        if (w_in_range) begin
            r_rdata <= r_mem[w_idx];
        end else begin
            r_rdata <= '0;
        end
    end

endmodule

// File: rtl/spi_ram_bridge.sv
// Serial command bridge: shifts in {cmd, payload} frames on SS_n/MOSI, updates
// independent write/read pointers, and streams read words MSB first on MISO.
module spi_ram_bridge
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 256,
    parameter int AUTO_INC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic frame_err
);

    localparam int FW = frame_w(ADDR_W, DATA_W);
    localparam int PW = FW - 2;
    localparam int CW = $clog2(FW + 1);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    state_e            r_state;
    logic [FW-1:0]     r_shift;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [DATA_W-1:0] r_tx;
    logic              r_miso;
    logic              r_frame_err;

    cmd_e              w_cmd;
    cmd_e              w_pre_cmd;
    logic [PW-1:0]     w_payload;
    logic              w_last_bit;
    logic              w_wr_oor;
    logic              w_rd_oor;
    logic              w_mem_we;
    logic              w_wr_sel;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_rdata;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        if ({1'b0, p} >= DEPTH_V - 1'b1) begin
            return '0;
        end
        return p + ADDR_W'(1);
    endfunction

    // w_pre_cmd sees the command one bit early so the range error lands in EXEC
    assign w_cmd      = cmd_e'(r_shift[PW+1:PW]);
    assign w_pre_cmd  = cmd_e'(r_shift[PW:PW-1]);
    assign w_payload  = r_shift[PW-1:0];
    assign w_last_bit = (r_cnt == CW'(FW - 1));
    assign w_wr_oor   = ({1'b0, r_wr_ptr} >= DEPTH_V);
    assign w_rd_oor   = ({1'b0, r_rd_ptr} >= DEPTH_V);
    assign w_wr_sel   = (r_state == EXEC) && (w_cmd == CMD_WR_DATA);
    assign w_mem_we   = w_wr_sel && !w_wr_oor;
    assign w_mem_addr = w_wr_sel ? r_wr_ptr : r_rd_ptr;
    assign MISO       = r_miso;
    assign frame_err  = r_frame_err;

    spi_ram_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_payload[DATA_W-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_miso      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_miso      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!SS_n) begin
                        r_state <= RX;
                        r_cnt   <= CW'(1);
                    end
                end
                RX: begin
                    if (SS_n) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_frame_err <= 1'b1;
                    end else if (w_last_bit) begin
                        r_state     <= EXEC;
                        r_cnt       <= '0;
                        r_frame_err <= ((w_pre_cmd == CMD_WR_DATA) && w_wr_oor) ||
                                       ((w_pre_cmd == CMD_RD_DATA) && w_rd_oor);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                EXEC: begin
                    case (w_cmd)
                        CMD_WR_ADDR: r_wr_ptr <= w_payload[ADDR_W-1:0];
                        CMD_WR_DATA: if (AUTO_INC != 0) r_wr_ptr <= next_ptr(r_wr_ptr);
                        CMD_RD_ADDR: r_rd_ptr <= w_payload[ADDR_W-1:0];
                        default:     if (AUTO_INC != 0) r_rd_ptr <= next_ptr(r_rd_ptr);
                    endcase
                    if (w_cmd == CMD_RD_DATA) begin
                        r_state <= TX;
                        r_cnt   <= CW'(1);
                        r_miso  <= w_rdata[DATA_W-1];
                    end else begin
                        r_state <= SS_n ? IDLE : WAIT_HI;
                    end
                end
                TX: begin
                    if (r_cnt == CW'(DATA_W)) begin
                        r_state <= SS_n ? IDLE : WAIT_HI;
                        r_cnt   <= '0;
                    end else if (SS_n) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_frame_err <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                        r_miso <= r_tx[DATA_W-1];
                    end
                end
                WAIT_HI: begin
                    if (SS_n) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Datapath shift registers carry no reset; r_cnt and the FSM qualify them
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) || (r_state == RX)) begin
            r_shift <= {r_shift[FW-2:0], MOSI};
        end
        if (r_state == EXEC) begin
            r_tx <= w_rdata << 1;
        end else if (r_state == TX) begin
            r_tx <= r_tx << 1;
        end
    end

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Directed bench for spi_ram_bridge: default 8/8/256 instance plus a
// 4-bit address, 12-bit data, 10-word instance sharing MOSI.
module tb_spi_ram_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ss0, ss1, mosi;
    logic        miso0, miso1, err0, err1;
    int          checks = 0;
    int          failures = 0;
    logic        exec_err;
    logic [15:0] rword;
    logic        seen;
    logic [9:0]  ab;

    always #5 clk = ~clk;

    spi_ram_bridge u0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (ss0),
        .MOSI      (mosi),
        .MISO      (miso0),
        .frame_err (err0)
    );

    spi_ram_bridge #(.ADDR_W(4), .DATA_W(12), .DEPTH(10), .AUTO_INC(1)) u1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (ss1),
        .MOSI      (mosi),
        .MISO      (miso1),
        .frame_err (err1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ss(input bit which, input logic v);
        if (which) ss1 = v;
        else       ss0 = v;
    endtask

    // Leaves the bench at the falling edge inside the EXEC cycle (L+1)
    task automatic shift_in(input bit which, input logic [1:0] cmd, input logic [15:0] pl,
                            input int pw);
        for (int i = 0; i < pw + 2; i++) begin
            set_ss(which, 1'b0);
            mosi = (i < 2) ? cmd[1-i] : pl[pw+1-i];
            @(negedge clk);
        end
        exec_err = which ? err1 : err0;
    endtask

    task automatic wframe(input bit which, input logic [1:0] cmd, input logic [15:0] pl,
                          input int pw);
        shift_in(which, cmd, pl, pw);
        set_ss(which, 1'b1);
        mosi = 1'b0;
        @(negedge clk);
    endtask

    task automatic rframe(input bit which, input int pw, input int dw);
        shift_in(which, 2'b11, 16'h0000, pw);
        rword = '0;
        for (int k = 0; k < dw; k++) begin
            @(negedge clk);
            rword = {rword[14:0], (which ? miso1 : miso0)};
        end
        @(negedge clk);
        set_ss(which, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        ss0   = 1'b1;
        ss1   = 1'b1;
        mosi  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso0", 16'(miso0), 16'h0);
        chk("rst_err0",  16'(err0),  16'h0);
        chk("rst_miso1", 16'(miso1), 16'h0);
        chk("rst_err1",  16'(err1),  16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write then read of 0xA5 at 0x10
        wframe(0, 2'b00, 16'h10, 8);
        wframe(0, 2'b01, 16'hA5, 8);
        chk("wr_a5_err", 16'(exec_err), 16'h0);
        wframe(0, 2'b10, 16'h10, 8);
        rframe(0, 8, 8);
        chk("rd_a5", rword, 16'h00A5);
        chk("rd_a5_err", 16'(exec_err), 16'h0);

        // Auto-increment across the 0xFF -> 0x00 wrap
        wframe(0, 2'b00, 16'hFE, 8);
        wframe(0, 2'b01, 16'h11, 8);
        wframe(0, 2'b01, 16'h22, 8);
        wframe(0, 2'b01, 16'h33, 8);
        wframe(0, 2'b10, 16'hFE, 8);
        rframe(0, 8, 8);
        chk("wrap_rd0", rword, 16'h0011);
        rframe(0, 8, 8);
        chk("wrap_rd1", rword, 16'h0022);
        rframe(0, 8, 8);
        chk("wrap_rd2", rword, 16'h0033);

        // Aborted write after five bits leaves memory and pointer untouched
        wframe(0, 2'b00, 16'h01, 8);
        wframe(0, 2'b01, 16'h5C, 8);
        wframe(0, 2'b00, 16'h01, 8);
        ab = {2'b01, 8'h77};
        for (int i = 0; i < 5; i++) begin
            ss0  = 1'b0;
            mosi = ab[9-i];
            @(negedge clk);
        end
        ss0  = 1'b1;
        mosi = 1'b0;
        @(negedge clk);
        chk("abort_err_hi", 16'(err0), 16'h1);
        @(negedge clk);
        chk("abort_err_lo", 16'(err0), 16'h0);
        wframe(0, 2'b10, 16'h01, 8);
        rframe(0, 8, 8);
        chk("abort_keep", rword, 16'h005C);
        wframe(0, 2'b01, 16'h99, 8);
        wframe(0, 2'b10, 16'h01, 8);
        rframe(0, 8, 8);
        chk("abort_ptr", rword, 16'h0099);

        // Reset during TX of 0xA5
        wframe(0, 2'b10, 16'h10, 8);
        shift_in(0, 2'b11, 16'h0000, 8);
        @(negedge clk);
        chk("tx_bit7", 16'(miso0), 16'h1);
        @(negedge clk);
        chk("tx_bit6", 16'(miso0), 16'h0);
        @(negedge clk);
        chk("tx_bit5", 16'(miso0), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_tx_miso", 16'(miso0), 16'h0);
        ss0 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wframe(0, 2'b01, 16'h3C, 8);
        rframe(0, 8, 8);
        chk("post_rst", rword, 16'h003C);

        // SS_n held low after a pointer load while MOSI toggles
        shift_in(0, 2'b00, 16'h20, 8);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mosi = i[0];
            @(negedge clk);
            seen = seen | miso0 | err0;
        end
        chk("wait_quiet", 16'(seen), 16'h0);
        ss0  = 1'b1;
        mosi = 1'b0;
        @(negedge clk);
        wframe(0, 2'b01, 16'h66, 8);
        wframe(0, 2'b10, 16'h20, 8);
        rframe(0, 8, 8);
        chk("wait_rd", rword, 16'h0066);

        // Narrow address, wide data, DEPTH=10 instance
        wframe(1, 2'b00, 16'h009, 12);
        wframe(1, 2'b01, 16'hABC, 12);
        chk("n_wr9_err", 16'(exec_err), 16'h0);
        wframe(1, 2'b10, 16'h009, 12);
        rframe(1, 12, 12);
        chk("n_rd9", rword, 16'h0ABC);
        wframe(1, 2'b00, 16'h00C, 12);
        wframe(1, 2'b01, 16'h123, 12);
        chk("n_wr12_err", 16'(exec_err), 16'h1);
        wframe(1, 2'b10, 16'h00C, 12);
        rframe(1, 12, 12);
        chk("n_rd12_err", 16'(exec_err), 16'h1);
        chk("n_rd12", rword, 16'h0000);
        chk("n_err_idle", 16'(err1), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_ram_bridge.md
SPI_RAM_BRIDGE -- requirements
Module: spi_ram_bridge

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width in bits.
REQ-002 Parameter DATA_W, default 8, RAM word width in bits.
REQ-003 Parameter DEPTH, default 256, number of RAM words; legal range 2..2**ADDR_W.
REQ-004 Parameter AUTO_INC, default 1, nonzero enables pointer post-increment after each data access.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SS_n  input  1  slave select, active-low, synchronous to clk.
REQ-008 MOSI  input  1  serial data in, sampled on rising clk.
REQ-009 MISO  output  1  serial data out, registered.
REQ-010 frame_err  output  1  one-cycle pulse on aborted or malformed frame.

Function
REQ-011 PW = max(ADDR_W, DATA_W); frame = 2 command bits then PW payload bits, MSB first, one bit per clk while SS_n low.
REQ-012 FSM states: IDLE, RX, EXEC, TX, WAIT_HI.
REQ-013 IDLE -> RX when SS_n sampled low; that same cycle's MOSI is frame bit 0 (cmd MSB).
REQ-014 RX counts 2+PW bits; after the last bit -> EXEC; cycle L denotes the cycle the last bit was sampled.
REQ-015 EXEC (cycle L+1) decodes cmd: 00 load wr_ptr; 01 write; 10 load rd_ptr; 11 read.
REQ-016 Cmd 00/10: pointer <= payload[ADDR_W-1:0]; payload bits above ADDR_W ignored.
REQ-017 Cmd 01: mem[wr_ptr] <= payload[DATA_W-1:0] at the end of cycle L+1; if AUTO_INC, wr_ptr <= (wr_ptr+1) mod DEPTH.
REQ-018 Cmd 11: word read from mem[rd_ptr] in cycle L+1; if AUTO_INC, rd_ptr <= (rd_ptr+1) mod DEPTH; FSM -> TX.
REQ-019 TX: MISO carries data bit DATA_W-1 down to bit 0 in cycles L+2 .. L+1+DATA_W; MOSI ignored during TX.
REQ-020 After EXEC (cmd 00/01/10) or after the last TX bit: if SS_n is high -> IDLE, else -> WAIT_HI; WAIT_HI ignores MOSI and exits to IDLE when SS_n is high.
REQ-021 MISO = 0 in every state except TX.
REQ-022 SS_n high in RX or TX: abort, -> IDLE next cycle, no RAM write, no pointer change, frame_err pulses for 1 cycle.
REQ-023 Pointer >= DEPTH (only possible when DEPTH < 2**ADDR_W): write suppressed, read returns all zeros, frame_err pulses in EXEC, auto-increment wraps to 0.
REQ-024 Wrap-around: pointer DEPTH-1 increments to 0.
REQ-025 Write and read pointers are independent; a write to mem[rd_ptr] is visible to any later read frame.

Reset
REQ-026 rst_n low asynchronously forces: state IDLE, wr_ptr 0, rd_ptr 0, bit counter 0, MISO 0, frame_err 0.
REQ-027 RAM contents are not reset and are undefined until written.
REQ-028 Reset asserted mid-frame discards the frame; the first frame after release starts with SS_n sampled low in IDLE.

Structure
REQ-029 Package spi_ram_pkg holds the command enum (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA), the FSM state enum, and a frame-width function of ADDR_W and DATA_W.
REQ-030 RAM is a sub-module spi_ram_mem: single-port, synchronous write, registered read, parameters ADDR_W/DATA_W/DEPTH, no reset.
REQ-031 Serial shift, bit counter, FSM and pointers reside in spi_ram_bridge.

Verification
REQ-032 Defaults: frame 00/0x10, then 01/0xA5, then 10/0x10, then 11 -> MISO = 1010_0101 in cycles L+2..L+9.
REQ-033 AUTO_INC=1: wr_ptr 0xFE; writes 0x11, 0x22, 0x33; rd_ptr 0xFE; three reads -> 0x11, 0x22, 0x33 (wrap to 0x00 confirmed).
REQ-034 SS_n high after 5 bits of a 01/0x77 frame -> frame_err pulse 1 cycle, the later read of the target address returns its prior value.
REQ-035 ADDR_W=4, DATA_W=12, DEPTH=10: write 0xABC at address 9, read back -> 0xABC; write at address 12 -> frame_err, read of address 12 returns 0x000.
REQ-036 rst_n low during TX of 0xA5 -> MISO 0 immediately, pointers 0; the next frame decodes correctly.
REQ-037 SS_n held low 6 cycles after cmd 00 frame, extra MOSI toggling -> no state change until SS_n high, then IDLE.
